// File: rtl/led_sequencer_if.sv
// Bus interface for led_sequencer: the step strobe and raw button go in,
// the LED drive and current mode come out.
interface led_sequencer_if;
  logic       tick;
  logic       mode_btn;
  logic [4:0] led;
  logic [1:0] mode;

  // Stimulus side: drives the strobe and button, observes the outputs.
  modport master (
    output tick,
    output mode_btn,
    input  led,
    input  mode
  );

  // Sequencer side: consumes the strobe and button, drives the outputs.
  modport slave (
    input  tick,
    input  mode_btn,
    output led,
    output mode
  );
endinterface

// File: rtl/led_sequencer.sv
// led_sequencer: 5-LED pattern generator.
// A debounced pushbutton cycles through four patterns (bounce, chase, count,
// blink), and an external tick strobe steps the active pattern.
// Optional feature macro: LED_SEQ_DIM_EN adds PWM dimming of the LED drive
// using a free-running 4-bit frame counter and PWM_DUTY on-slots per frame.
module led_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 20800,
  parameter logic [3:0]  PWM_DUTY        = 4'd8
) (
  input logic            clk,
  input logic            rst,
  led_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam int unsigned    CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_meta;
  logic             btn_sync;
  logic             db_level;
  logic [CNT_W-1:0] db_cnt;
  logic             db_accept;
  logic             advance;

  mode_e            mode_q;
  mode_e            mode_next;

  logic [4:0]       pattern_q;
  logic [4:0]       pattern_next;
  logic             dir_up_q;
  logic             dir_up_next;

  // Starting pattern shown whenever a mode is entered.
  function automatic logic [4:0] init_pattern(input mode_e m);
    logic [4:0] p;
    case (m)
      MODE_BOUNCE: p = 5'b00001;
      MODE_CHASE:  p = 5'b00001;
      MODE_COUNT:  p = 5'b00000;
      default:     p = 5'b11111;
    endcase
    return p;
  endfunction

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= bus.mode_btn;
      btn_sync <= btn_meta;
    end
  end

  // A level change is accepted on the last of DEBOUNCE_CYCLES consecutive
  // differing samples; only an accepted rising level advances the mode.
  assign db_accept = (btn_sync != db_level) && (db_cnt == DB_LAST);
  assign advance   = db_accept && btn_sync;

  // Debouncer: count consecutive differing samples, any match restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else if (btn_sync == db_level) begin
      db_cnt <= '0;
    end else if (db_accept) begin
      db_level <= btn_sync;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

  // Mode state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_BOUNCE;
    end else begin
      mode_q <= mode_next;
    end
  end

  // Next mode: step forward on each accepted press, wrapping 3 -> 0.
  always_comb begin
    mode_next = mode_q;
    if (advance) begin
      mode_next = mode_e'(mode_q + 2'd1);
    end
  end

  // Pattern update: a mode change reloads the pattern and swallows any
  // coincident tick; otherwise a tick steps the current pattern once.
  always_comb begin
    pattern_next = pattern_q;
    dir_up_next  = dir_up_q;
    if (advance) begin
      pattern_next = init_pattern(mode_next);
      dir_up_next  = 1'b1;
    end else if (bus.tick) begin
      case (mode_q)
        MODE_BOUNCE: begin
          if (dir_up_q) begin
            if (pattern_q[3]) begin
              pattern_next = 5'b10000;
              dir_up_next  = 1'b0;
            end else begin
              pattern_next = {pattern_q[3:0], 1'b0};
            end
          end else begin
            if (pattern_q[1]) begin
              pattern_next = 5'b00001;
              dir_up_next  = 1'b1;
            end else begin
              pattern_next = {1'b0, pattern_q[4:1]};
            end
          end
        end
        MODE_CHASE:  pattern_next = {pattern_q[3:0], pattern_q[4]};
        MODE_COUNT:  pattern_next = pattern_q + 5'd1;
        default:     pattern_next = ~pattern_q;
      endcase
    end
  end

  // Pattern and bounce-direction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= 5'b00001;
      dir_up_q  <= 1'b1;
    end else begin
      pattern_q <= pattern_next;
      dir_up_q  <= dir_up_next;
    end
  end

`ifdef LED_SEQ_DIM_EN
  logic [3:0] pwm_cnt;
  logic       pwm_on;

  // Free-running PWM frame counter, 16 slots per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= 4'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  assign pwm_on = (pwm_cnt < PWM_DUTY);

  // Outputs: pattern gated by the PWM on-window, plus the current mode.
  always_comb begin
    bus.led  = pattern_q & {5{pwm_on}};
    bus.mode = mode_q;
  end
`else
  // PWM_DUTY has no effect without dimming; fold it into a sink so the
  // parameter stays referenced.
  logic unused_pwm_duty;
  assign unused_pwm_duty = ^PWM_DUTY;

  // Outputs: pattern register drives the LEDs directly, plus the mode.
  always_comb begin
    bus.led  = pattern_q;
    bus.mode = mode_q;
  end
`endif

endmodule
